// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB3 bus bundle between the requester bridge and a register-file slave
interface apb_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  PSELx;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding command/response to APB3 requester bridge with wait timeout
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    apb_master_if.master          apb
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the edge where the next low-PREADY cycle would reach the limit
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWRITE  <= 1'b0;
            apb.PWDATA  <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        apb.PADDR  <= cmd_addr;
                        apb.PWRITE <= cmd_write;
                        if (cmd_write) begin
                            apb.PWDATA <= cmd_wdata;
                        end
                        apb.PSELx  <= 1'b1;
                        cmd_ready  <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over the timeout when both land on the same edge
                    if (apb.PREADY) begin
                        rsp_rdata   <= (apb.PWRITE || apb.PSLVERR) ? '0 : apb.PRDATA;
                        rsp_err     <= apb.PSLVERR;
                        rsp_valid   <= 1'b1;
                        apb.PSELx   <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= RESP;
                    end else begin
                        if (wait_cnt != {CW{1'b1}}) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (TO_EN && (wait_cnt == TO_LAST)) begin
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_valid   <= 1'b1;
                            apb.PSELx   <= 1'b0;
                            apb.PENABLE <= 1'b0;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .apb      (apb)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] mem [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command, play the slave side, report latency from the accept edge
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input int nwait, input logic slverr, input logic use_mem,
                        input logic [DW-1:0] rd, output int lat, output int n_access,
                        output logic [DW-1:0] got_rd, output logic got_err);
        int w;
        lat      = -1;
        n_access = 0;
        w        = 0;
        got_rd   = 'x;
        got_err  = 1'bx;
        check("ready_before", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_addr    = addr;
        cmd_write   = wr;
        cmd_wdata   = wd;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        check("setup_psel", apb.PSELx, 1);
        check("setup_pen", apb.PENABLE, 0);
        check("setup_ready", cmd_ready, 0);
        for (int cyc = 1; cyc < 40 && lat < 0; cyc++) begin
            if (rsp_valid) begin
                lat     = cyc;
                got_rd  = rsp_rdata;
                got_err = rsp_err;
            end else begin
                if (apb.PSELx && apb.PENABLE) begin
                    n_access++;
                    check("paddr_stable", apb.PADDR, addr);
                    check("pwrite_stable", apb.PWRITE, wr);
                    if (wr) check("pwdata_stable", apb.PWDATA, wd);
                    if (w < nwait) begin
                        apb.PREADY = 1'b0;
                        w++;
                    end else begin
                        apb.PREADY  = 1'b1;
                        apb.PSLVERR = slverr;
                        apb.PRDATA  = use_mem ? mem[addr[7:2]] : rd;
                        if (wr && use_mem) mem[addr[7:2]] = wd;
                    end
                end
                tick();
            end
        end
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = $urandom;
        if (lat < 0) check("rsp_never_seen", 0, 1);
        tick();
        check("rsp_one_cycle", rsp_valid, 0);
        check("ready_after", cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nacc, ones;
        logic [DW-1:0] rd;
        logic err;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        PRESETn = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
        #1 PRESETn = 1'b0;

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            cmd_valid   = 1'($urandom);
            cmd_addr    = AW'($urandom);
            cmd_write   = 1'($urandom);
            cmd_wdata   = $urandom;
            apb.PREADY  = 1'($urandom);
            apb.PRDATA  = $urandom;
            apb.PSLVERR = 1'($urandom);
            tick();
        end
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_psel", apb.PSELx, 0);
        check("rst_penable", apb.PENABLE, 0);
        check("rst_paddr", apb.PADDR, 0);
        check("rst_pwrite", apb.PWRITE, 0);
        check("rst_pwdata", apb.PWDATA, 0);
        cmd_valid = 1'b0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
        #2 PRESETn = 1'b1;
        #1 check("rst_release_ready", cmd_ready, 1);
        tick();

        // Zero-wait write
        xfer(16'h0040, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0, '0, lat, nacc, rd, err);
        check("wr0_latency", lat, 3);
        check("wr0_access_cycles", nacc, 1);
        check("wr0_err", err, 0);
        check("wr0_rdata", rd, 0);
        check("wr0_paddr_hold", apb.PADDR, 16'h0040);

        // Read with three wait states; PWDATA must keep the earlier write data
        xfer(16'h0080, 1'b0, 32'h0BADF00D, 3, 1'b0, 1'b0, 32'h12345678, lat, nacc, rd, err);
        check("rdw_latency", lat, 6);
        check("rdw_access_cycles", nacc, 4);
        check("rdw_rdata", rd, 32'h12345678);
        check("rdw_err", err, 0);
        check("rdw_pwdata_kept", apb.PWDATA, 32'hDEADBEEF);
        check("rdw_rdata_hold", rsp_rdata, 32'h12345678);

        // Timeout: PREADY never rises
        xfer(16'h0100, 1'b0, '0, 100, 1'b0, 1'b0, 32'hFFFFFFFF, lat, nacc, rd, err);
        check("to_latency", lat, 6);
        check("to_access_cycles", nacc, 4);
        check("to_err", err, 1);
        check("to_rdata", rd, 0);

        // PREADY on the edge the counter would hit the limit: normal completion
        xfer(16'h0104, 1'b0, '0, 3, 1'b0, 1'b0, 32'hCAFEF00D, lat, nacc, rd, err);
        check("edge_latency", lat, 6);
        check("edge_err", err, 0);
        check("edge_rdata", rd, 32'hCAFEF00D);

        // Slave error on read and on write
        xfer(16'h0200, 1'b0, '0, 0, 1'b1, 1'b0, 32'h00000055, lat, nacc, rd, err);
        check("slverr_rd_err", err, 1);
        check("slverr_rd_rdata", rd, 0);
        xfer(16'h0204, 1'b1, 32'h11112222, 1, 1'b1, 1'b0, '0, lat, nacc, rd, err);
        check("slverr_wr_err", err, 1);
        check("slverr_wr_latency", lat, 4);

        // Reset during ACCESS
        cmd_valid = 1'b1; cmd_addr = 16'h0300; cmd_write = 1'b1; cmd_wdata = 32'h77778888;
        apb.PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_in_access", apb.PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        check("mid_psel_async", apb.PSELx, 0);
        check("mid_pen_async", apb.PENABLE, 0);
        apb.PREADY = 1'b1;
        @(posedge PCLK);
        #3 PRESETn = 1'b1;
        #1 check("mid_ready", cmd_ready, 1);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid || apb.PSELx) ones++;
        end
        check("mid_no_rsp", ones, 0);
        apb.PREADY = 1'b0;

        // End-to-end against a register-file model, back-to-back
        xfer(16'h03c0, 1'b1, 32'hA5A5A5A5, 0, 1'b0, 1'b1, '0, lat, nacc, rd, err);
        check("e2e_wr_err", err, 0);
        xfer(16'h03c0, 1'b0, '0, 0, 1'b0, 1'b1, '0, lat, nacc, rd, err);
        check("e2e_rd_err", err, 0);
        check("e2e_rd_data", rd, 32'hA5A5A5A5);
        check("e2e_rd_latency", lat, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/apb_master.md
# apb_master

Requester-side APB3 bridge that turns a simple command/response handshake from internal logic into APB transfers toward the APB register-file slave. It runs one transfer at a time through SETUP and ACCESS phases and waits on PREADY. It returns read data or an error flag on a single-cycle response strobe, and aborts a stalled transfer with a programmable timeout.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data
- ADDR_WIDTH, 16, width of PADDR and command address
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR seen or timeout; valid with rsp_valid
- PSELx  out  1  slave select
- PENABLE  out  1  ACCESS-phase indicator
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  slave ready / transfer complete
- PRDATA  in  DATA_WIDTH  slave read data
- PSLVERR  in  1  slave error; tie 0 for slaves without it

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs come from registers; no combinational path from PREADY to any output.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
  - If cmd_write = 0, PWDATA keeps its previous value.
- SETUP: PSELx = 1, PENABLE = 0. Always goes to ACCESS next cycle.
- ACCESS:
  - PSELx = 1, PENABLE = 1.
  - PADDR/PWRITE/PWDATA stay stable from SETUP until ACCESS exits.
  - On an edge with PREADY = 1: capture PRDATA into rsp_rdata (write: 0), capture PSLVERR into rsp_err, go to RESP.
  - Each edge with PREADY = 0 increments the wait counter. When the counter reaches TIMEOUT_CYCLES (non-zero), go to RESP with rsp_err = 1 and rsp_rdata = 0.
- RESP:
  - PSELx = 0, PENABLE = 0, rsp_valid = 1 for exactly one cycle, cmd_ready = 0.
  - Next state is always IDLE.
- There is no response backpressure; the consumer must sample rsp_* while rsp_valid = 1.
- rsp_rdata/rsp_err hold their values until the next response.
- PADDR/PWRITE/PWDATA hold their last values in IDLE/RESP and do not return to 0.
- Wait counter: width sized to hold TIMEOUT_CYCLES; clears on SETUP entry; saturates, never wraps.
- PREADY and PSLVERR are ignored outside ACCESS.
- cmd_valid is ignored outside IDLE; commands are never queued.

## Timing
- Reset values:
  - State IDLE, cmd_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - PSELx = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0.
  - Wait counter = 0.
- Reset asserted mid-transfer: PSELx/PENABLE drop immediately (asynchronously). The command is lost and no rsp_valid is ever produced for it.
- Command accepted at edge T:
  - SETUP during cycle T+1.
  - ACCESS from T+2.
  - With PREADY high at the first ACCESS edge: rsp_valid during T+3, cmd_ready high again during T+4.
- Each wait cycle (PREADY = 0 in ACCESS) adds one cycle to that latency.
- Minimum command-to-command spacing: 4 cycles.
- Timeout with TIMEOUT_CYCLES = N and PREADY held low: ACCESS lasts N cycles, then rsp_valid with rsp_err = 1.
- If PREADY rises on the same edge the counter would reach N, the transfer completes normally with rsp_err = PSLVERR.

## Test plan
- Reset check: assert PRESETn = 0 with random inputs → every output at its reset value; cmd_ready = 1 within the same cycle of deassertion.
- Zero-wait write:
  - Stimulus: cmd addr 0x0040, data 0xDEADBEEF; PREADY tied 1.
  - Response: PSELx high for 2 cycles, PENABLE high for 1; PADDR = 0x0040 and PWDATA = 0xDEADBEEF stable across both; rsp_valid at T+3 with rsp_err = 0, rsp_rdata = 0.
- Read with wait states:
  - Stimulus: read 0x0080; PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x12345678.
  - Response: rsp_valid at T+6, rsp_rdata = 0x12345678, rsp_err = 0.
- Timeout: TIMEOUT_CYCLES = 4, PREADY held 0 → exactly 4 ACCESS cycles, then rsp_valid with rsp_err = 1, rsp_rdata = 0, then IDLE.
- Error and reset mid-op:
  - PSLVERR = 1 with PREADY = 1 → rsp_err = 1.
  - A second transfer reset during ACCESS → PSELx = 0 immediately, no rsp_valid afterward.
- End-to-end against apb_wrapper:
  - Stimulus: write 0xA5A5A5A5 to 0x03c0, then read 0x03c0 back-to-back.
  - Response: read rsp_rdata = 0xA5A5A5A5, both rsp_err = 0.
